// File: rtl/dual_port_ram_fifo_ctrl_if.sv
// dual_port_ram_fifo_ctrl_if: producer/consumer handshake and status bundle for the FIFO controller
interface dual_port_ram_fifo_ctrl_if #(parameter int MSB = 8, parameter int addrsize = 8);
  logic                wr_en;
  logic [MSB-1:0]      wdata;
  logic                rd_en;
  logic [MSB-1:0]      rdata;
  logic                full;
  logic                empty;
  logic [addrsize:0]   count;
  modport master (output wr_en, wdata, rd_en, input rdata, full, empty, count);
  modport slave  (input wr_en, wdata, rd_en, output rdata, full, empty, count);
endinterface

// File: rtl/dual_port_ram_fifo_ctrl.sv
// dual_port_ram_fifo_ctrl: FWFT FIFO sequencing an external dual_port_ram; DUAL_PORT_RAM_FIFO_CTRL_ERR_EN adds sticky ovf/udf flags
module dual_port_ram_fifo_ctrl #(
  parameter int MSB      = 8,
  parameter int addrsize = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_port_ram_fifo_ctrl_if.slave bus,
  output logic                 ram_we,
  output logic [addrsize-1:0]  ram_wa,
  output logic [MSB-1:0]       ram_wd,
  output logic [addrsize-1:0]  ram_ra,
  input  logic [MSB-1:0]       ram_rd
`ifdef DUAL_PORT_RAM_FIFO_CTRL_ERR_EN
  ,
  input  logic                 err_clr,
  output logic                 ovf,
  output logic                 udf
`endif
);
  logic [addrsize:0] wptr, rptr;
  logic push, pop;
  assign bus.empty = wptr == rptr;
  assign bus.full  = (wptr[addrsize] != rptr[addrsize]) && (wptr[addrsize-1:0] == rptr[addrsize-1:0]);
  assign bus.count = wptr - rptr;
  assign bus.rdata = ram_rd;
  assign push = bus.wr_en & ~bus.full;
  assign pop  = bus.rd_en & ~bus.empty;
  assign ram_we = push & rst_n;
  assign ram_wa = wptr[addrsize-1:0];
  assign ram_wd = bus.wdata;
  assign ram_ra = rptr[addrsize-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (addrsize+1)'(push);
      rptr <= rptr + (addrsize+1)'(pop);
    end
`ifdef DUAL_PORT_RAM_FIFO_CTRL_ERR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (bus.wr_en & bus.full) | (ovf & ~err_clr);
      udf <= (bus.rd_en & bus.empty) | (udf & ~err_clr);
    end
`endif
endmodule

// File: tb/tb_dual_port_ram_fifo_ctrl.sv
// tb_dual_port_ram_fifo_ctrl: randomized scoreboard bench with a queue-based FIFO model and behavioural RAM
module tb_dual_port_ram_fifo_ctrl;
  localparam int W = 8, A = 3, D = 1 << A;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ram_we;
  logic [A-1:0] ram_wa, ram_ra;
  logic [W-1:0] ram_wd, ram_rd;
  logic [W-1:0] mem [D];
  int checks = 0, failures = 0;
  logic [W-1:0] mq [$];
  logic [W-1:0] sb [$];
  int npush = 0, npop = 0;
  logic [W-1:0] dv = 8'h00;
`ifdef DUAL_PORT_RAM_FIFO_CTRL_ERR_EN
  logic err_clr = 1'b0, ovf, udf;
  logic m_ovf = 1'b0, m_udf = 1'b0;
`endif
  dual_port_ram_fifo_ctrl_if #(.MSB(W), .addrsize(A)) bus ();
  dual_port_ram_fifo_ctrl #(.MSB(W), .addrsize(A)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_wd(ram_wd), .ram_ra(ram_ra), .ram_rd(ram_rd)
`ifdef DUAL_PORT_RAM_FIFO_CTRL_ERR_EN
    , .err_clr(err_clr), .ovf(ovf), .udf(udf)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we) mem[ram_wa] <= ram_wd;
  assign ram_rd = mem[ram_ra];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.rd_en && !bus.empty) begin
      chk("pop_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk("rdata", 32'(bus.rdata), 32'(sb.pop_front()));
    end
  task automatic status(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'(mq.size()));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(mq.size() == 0));
    chk({tag, "_full"}, 32'(bus.full), 32'(mq.size() == D));
    chk({tag, "_ram_wa"}, 32'(ram_wa), 32'(npush % D));
    chk({tag, "_ram_ra"}, 32'(ram_ra), 32'(npop % D));
`ifdef DUAL_PORT_RAM_FIFO_CTRL_ERR_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, "_udf"}, 32'(udf), 32'(m_udf));
`endif
  endtask
  task automatic step(input logic w, input logic r, input logic [W-1:0] d, input logic c = 1'b0);
    logic do_push, do_pop;
    int sz;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.wdata = d;
`ifdef DUAL_PORT_RAM_FIFO_CTRL_ERR_EN
    err_clr = c;
`endif
    sz = mq.size();
    do_push = w && sz < D;
    do_pop  = r && sz > 0;
    #1 chk("ram_we", 32'(ram_we), 32'(do_push));
    if (do_pop) sb.push_back(mq[0]);
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(mq.pop_front());
      npop++;
    end
    if (do_push) begin
      mq.push_back(d);
      npush++;
    end
`ifdef DUAL_PORT_RAM_FIFO_CTRL_ERR_EN
    m_ovf = (w && sz == D) || (m_ovf && !c);
    m_udf = (r && sz == 0) || (m_udf && !c);
`endif
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
`ifdef DUAL_PORT_RAM_FIFO_CTRL_ERR_EN
    err_clr = 1'b0;
`endif
    status("step");
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    status("reset");
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 8'(8'h11 + i));
    step(1'b1, 1'b0, 8'h99);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 1'b0, dv);
        dv++;
      end
      repeat (3) step(1'b0, 1'b1, 8'h00);
    end
    repeat (4) begin
      step(1'b1, 1'b0, dv);
      dv++;
    end
    repeat (10) begin
      step(1'b1, 1'b1, dv);
      dv++;
    end
    repeat (4) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h5A);
    repeat (7) begin
      step(1'b1, 1'b0, dv);
      dv++;
    end
    step(1'b1, 1'b1, 8'hEE);
    repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 7) == 0));
    while (mq.size() > 5) step(1'b0, 1'b1, 8'h00);
    while (mq.size() < 5) begin
      step(1'b1, 1'b0, dv);
      dv++;
    end
    #2;
    rst_n = 1'b0;
    bus.wr_en = 1'b1;
    #1;
    chk("async_count", 32'(bus.count), 32'd0);
    chk("async_empty", 32'(bus.empty), 32'd1);
    chk("async_full", 32'(bus.full), 32'd0);
    chk("async_ram_we", 32'(ram_we), 32'd0);
    mq.delete();
    npush = 0;
    npop = 0;
`ifdef DUAL_PORT_RAM_FIFO_CTRL_ERR_EN
    m_ovf = 1'b0;
    m_udf = 1'b0;
`endif
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    status("in_reset");
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hA5);
    chk("post_reset_rdata", 32'(bus.rdata), 32'hA5);
    step(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
